fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Sequences the 32-bit x 1024-word instruction memory.
- Boot: accepts a program from a loader port and writes it into instruction memory.
- Run: drives the word index (pc_out) every cycle and registers the fetched instruction toward decode.
- Handles decode stalls, branch redirects and a halt instruction.
- Sits between instruction memory and the decode stage.

Parameters:
RESET_PC, 0, word index where fetch starts after loading completes.
HALT_INSN, 32'h00000073, instruction encoding that halts fetch once it has been delivered to decode.
AW, 10, instruction memory word-address width (1024 words).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ld_valid  in  1  loader write request
ld_addr  in  AW  loader word index
ld_data  in  32  loader instruction word
ld_done  in  1  loader finished; start execution
ld_ready  out  1  loader writes accepted (LOAD state)
mem_we  out  1  instruction memory write enable
mem_waddr  out  AW  instruction memory write index
mem_wdata  out  32  instruction memory write data
pc_out  out  AW  instruction memory read index
insn_in  in  32  instruction memory read data (combinational read of pc_out)
if_valid  out  1  if_insn/if_pc hold a valid instruction
if_insn  out  32  fetched instruction to decode
if_pc  out  AW  index of if_insn
id_ready  in  1  decode accepts if_insn this cycle
br_taken  in  1  redirect request
br_target  in  AW  redirect word index
halted  out  1  fetch stopped on HALT_INSN
fetch_cnt  out  32  instructions delivered to decode, saturating

Behaviour:
- Reset, sampled on the rising edge of clk, is the only way out of HALT and takes priority mid-operation. On reset:
  - state=LOAD, pc=RESET_PC, if_valid=0, if_insn=0, if_pc=0, halted=0, fetch_cnt=0.
  - mem_we=0, ld_ready=1.
- States: LOAD, RUN, HALT. pc_out = pc register in every state.
- LOAD:
  - ld_ready=1.
  - mem_we=ld_valid, mem_waddr=ld_addr, mem_wdata=ld_data, all combinational.
  - if_valid=0; pc is held.
  - On ld_done go to RUN with pc=RESET_PC. If ld_valid and ld_done are asserted in the same cycle, the write still occurs.
- RUN / HALT: ld_ready=0 and mem_we=0; loader inputs are ignored.
- Advance condition in RUN: adv = !if_valid | id_ready.
- RUN, no branch, adv=1, at the edge:
  - if_insn<=insn_in, if_pc<=pc, if_valid<=1.
  - pc<=pc+1, mod 2^AW (1023 wraps to 0).
- RUN, no branch, adv=0: pc, if_insn, if_pc and if_valid are held (stall).
- Delivery: an instruction is delivered when if_valid & id_ready at an edge; fetch_cnt then increments and saturates at 32'hFFFFFFFF.
- Fetch latency: an instruction at index N appears on if_insn 1 cycle after pc=N is presented.
- Branch redirect (br_taken=1 in RUN):
  - pc<=br_target and if_valid<=0 (flush) next cycle, regardless of id_ready.
  - A delivery in the same cycle still counts.
  - Branch overrides both stall and sequential advance. The first redirected instruction is valid 2 cycles after the br_taken cycle.
- Halt:
  - When the delivered instruction equals HALT_INSN (if_valid & id_ready & if_insn==HALT_INSN): go to HALT, if_valid<=0, halted<=1, pc frozen. This is counted in fetch_cnt.
  - If br_taken occurs in the same cycle, halt wins.
  - A HALT_INSN that is fetched but not yet delivered does not halt.
- HALT: no fetch, if_valid=0, halted=1, br_taken ignored.
- fetch_cnt does not reset on LOAD->RUN.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding: LOAD=2'd0, RUN=2'd1, HALT=2'd2;
  - AW default;
  - HALT_INSN default;
  - instruction width 32.
- No sub-module required. The saturating counter may optionally be a small sat_counter module.

Test Plan:
- Load/start: load 4 words (0x00208093 at 0..3) with ld_valid, then ld_done -> mem_we pulses at addresses 0..3 and ld_ready drops. pc_out sequence is 0,1,2,3; if_insn is valid one cycle after each index is presented.
- Stall: id_ready=0 for 3 cycles while if_valid=1 with if_pc=2 -> pc_out holds 3, if_insn/if_pc are stable, and fetch_cnt does not increment.
- Branch with stall: br_taken=1, br_target=10, id_ready=0 -> next cycle if_valid=0 and pc_out=10; following cycle if_pc=10 with if_valid=1.
- Wrap: RESET_PC=1022, sequential fetch -> if_pc sequence is 1022, 1023, 0, 1.
- Halt: 0x00000073 at index 5, id_ready=1 -> after delivery halted=1, if_valid=0, and fetch_cnt=6. A later br_taken is ignored; rst returns to LOAD with halted=0 and fetch_cnt=0.
- Reset mid-run: assert rst with if_valid=1 -> next cycle state=LOAD, if_valid=0, ld_ready=1, pc_out=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch controller: state encoding,
// default address width and the halt instruction encoding.
package fetch_pkg;

  localparam int unsigned InsnW     = 32;
  localparam int unsigned AwDefault = 10;

  localparam logic [InsnW-1:0] HaltInsnDefault = 32'h0000_0073;

  localparam logic [1:0] StLoad = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

endpackage

// File: rtl/fetch_ctrl_sat_cnt.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module fetch_ctrl_sat_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: loads a program into instruction memory, then
// fetches sequentially toward decode with stall, redirect and halt handling.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned         AW        = AwDefault,
  parameter logic [AW-1:0]       RESET_PC  = '0,
  parameter logic [InsnW-1:0]    HALT_INSN = HaltInsnDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // Loader port
  input  logic             ld_valid_i,
  input  logic [AW-1:0]    ld_addr_i,
  input  logic [InsnW-1:0] ld_data_i,
  input  logic             ld_done_i,
  output logic             ld_ready_o,
  // Instruction memory
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_waddr_o,
  output logic [InsnW-1:0] mem_wdata_o,
  output logic [AW-1:0]    pc_out_o,
  input  logic [InsnW-1:0] insn_in_i,
  // Decode interface
  output logic             if_valid_o,
  output logic [InsnW-1:0] if_insn_o,
  output logic [AW-1:0]    if_pc_o,
  input  logic             id_ready_i,
  input  logic             br_taken_i,
  input  logic [AW-1:0]    br_target_i,
  // Status
  output logic             halted_o,
  output logic [31:0]      fetch_cnt_o
);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic             if_valid_q, if_valid_d;
  logic [InsnW-1:0] if_insn_q, if_insn_d;
  logic [AW-1:0]    if_pc_q, if_pc_d;
  logic             halted_q, halted_d;

  logic in_load, in_run, deliver, halt_hit, adv;

  assign in_load  = (state_q == StLoad);
  assign in_run   = (state_q == StRun);
  assign deliver  = in_run & if_valid_q & id_ready_i;
  assign halt_hit = deliver & (if_insn_q == HALT_INSN);
  assign adv      = ~if_valid_q | id_ready_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_insn_d  = if_insn_q;
    if_pc_d    = if_pc_q;
    halted_d   = halted_q;
    case (state_q)
      StLoad: begin
        if_valid_d = 1'b0;
        if (ld_done_i) begin
          state_d = StRun;
          pc_d    = RESET_PC;
        end
      end
      StRun: begin
        // Halt outranks redirect, which outranks stall/advance.
        if (halt_hit) begin
          state_d    = StHalt;
          if_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (br_taken_i) begin
          pc_d       = br_target_i;
          if_valid_d = 1'b0;
        end else if (adv) begin
          if_insn_d  = insn_in_i;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + AW'(1);
        end
      end
      StHalt: begin
        if_valid_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: begin
        state_d    = StLoad;
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StLoad;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_insn_q  <= '0;
      if_pc_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_insn_q  <= if_insn_d;
      if_pc_q    <= if_pc_d;
      halted_q   <= halted_d;
    end
  end

  fetch_ctrl_sat_cnt #(
    .Width (32)
  ) u_fetch_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (deliver),
    .cnt_o (fetch_cnt_o)
  );

  assign ld_ready_o  = in_load;
  assign mem_we_o    = in_load & ld_valid_i;
  assign mem_waddr_o = ld_addr_i;
  assign mem_wdata_o = ld_data_i;
  assign pc_out_o    = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_insn_o   = if_insn_q;
  assign if_pc_o     = if_pc_q;
  assign halted_o    = halted_q;

endmodule
